// File: rtl/cpu_sequencer.sv
// Fetch/decode/execute controller for the 4-bit-address core.
// Three-state instruction cycle with timed stalls, halt and in-code reset.
module cpu_sequencer #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              RUN,
    input  logic [DATA_W-1:0] ROM_DATA,
    input  logic              ZERO_FLAG,
    output logic              PC_INC,
    output logic              PC_LD,
    output logic [ADDR_W-1:0] PC_LD_ADDR,
    output logic [DATA_W-1:0] IR,
    output logic              ACC_LD,
    output logic [2:0]        ALU_OP,
    output logic [ADDR_W-1:0] OPERAND,
    output logic              OUT_LD,
    output logic              HALTED,
    output logic              ILLEGAL,
    output logic [2:0]        STATE,
    output logic [CNT_W-1:0]  RETIRED
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_STALL  = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_XOR  = 4'h6;
    localparam logic [3:0] OP_JMP  = 4'h7;
    localparam logic [3:0] OP_JZ   = 4'h8;
    localparam logic [3:0] OP_OUT  = 4'h9;
    localparam logic [3:0] OP_WAIT = 4'hA;
    localparam logic [3:0] OP_HLT  = 4'hE;
    localparam logic [3:0] OP_RST  = 4'hF;

    logic [2:0]        state_q, state_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [CNT_W-1:0]  retired_q, retired_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    // EXEC-cycle controls, loaded on the DECODE edge and cleared after EXEC
    logic              inc_q, inc_d;
    logic              ld_q, ld_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              acc_q, acc_d;
    logic [2:0]        alu_q, alu_d;
    logic              out_q, out_d;
    logic              ill_q, ill_d;
    logic              jz_q, jz_d;
    logic              wait_q, wait_d;
    logic              hlt_q, hlt_d;

    logic [3:0]        opcode;
    logic [ADDR_W-1:0] operand;
    logic              retire;
    logic              stall_last;

    assign opcode  = ir_q[DATA_W-1 -: 4];
    assign operand = ir_q[ADDR_W-1:0];

    always_comb begin
        inc_d  = 1'b0;
        ld_d   = 1'b0;
        addr_d = addr_q;
        acc_d  = 1'b0;
        alu_d  = 3'd0;
        out_d  = 1'b0;
        ill_d  = 1'b0;
        jz_d   = 1'b0;
        wait_d = 1'b0;
        hlt_d  = 1'b0;
        case (opcode)
            OP_NOP: inc_d = 1'b1;
            OP_LDI: begin
                acc_d = 1'b1;
                inc_d = 1'b1;
            end
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                acc_d = 1'b1;
                alu_d = opcode[2:0] - 3'd1;
                inc_d = 1'b1;
            end
            OP_JMP: begin
                ld_d   = 1'b1;
                addr_d = operand;
            end
            OP_JZ: begin
                jz_d   = 1'b1;
                addr_d = operand;
            end
            OP_OUT: begin
                out_d = 1'b1;
                inc_d = 1'b1;
            end
            OP_WAIT: begin
                wait_d = 1'b1;
                inc_d  = (operand == '0);
            end
            OP_HLT: hlt_d = 1'b1;
            OP_RST: begin
                ld_d   = 1'b1;
                addr_d = '0;
            end
            default: begin
                ill_d = 1'b1;
                inc_d = 1'b1;
            end
        endcase
    end

    assign stall_last = (state_q == S_STALL) && (cnt_q == ADDR_W'(1));

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        cnt_d   = cnt_q;
        retire  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (RUN) state_d = S_FETCH;
            end
            S_FETCH: begin
                ir_d    = ROM_DATA;
                state_d = S_DECODE;
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                if (wait_q) cnt_d = operand;
                if (hlt_q) begin
                    retire  = 1'b1;
                    state_d = S_HALT;
                end else if (wait_q && (operand != '0)) begin
                    state_d = S_STALL;
                end else begin
                    retire  = 1'b1;
                    state_d = RUN ? S_FETCH : S_IDLE;
                end
            end
            S_STALL: begin
                if (stall_last) begin
                    cnt_d   = '0;
                    retire  = 1'b1;
                    state_d = RUN ? S_FETCH : S_IDLE;
                end else begin
                    cnt_d = cnt_q - ADDR_W'(1);
                end
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
        retired_d = retired_q + CNT_W'(retire);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= S_IDLE;
            ir_q      <= '0;
            retired_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            retired_q <= retired_d;
            cnt_q     <= cnt_d;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            inc_q  <= 1'b0;
            ld_q   <= 1'b0;
            addr_q <= '0;
            acc_q  <= 1'b0;
            alu_q  <= 3'd0;
            out_q  <= 1'b0;
            ill_q  <= 1'b0;
            jz_q   <= 1'b0;
            wait_q <= 1'b0;
            hlt_q  <= 1'b0;
        end else if (state_q == S_DECODE) begin
            inc_q  <= inc_d;
            ld_q   <= ld_d;
            addr_q <= addr_d;
            acc_q  <= acc_d;
            alu_q  <= alu_d;
            out_q  <= out_d;
            ill_q  <= ill_d;
            jz_q   <= jz_d;
            wait_q <= wait_d;
            hlt_q  <= hlt_d;
        end else begin
            inc_q  <= 1'b0;
            ld_q   <= 1'b0;
            acc_q  <= 1'b0;
            alu_q  <= 3'd0;
            out_q  <= 1'b0;
            ill_q  <= 1'b0;
            jz_q   <= 1'b0;
            wait_q <= 1'b0;
            hlt_q  <= 1'b0;
        end
    end

    // Branch condition is resolved from the live flag during EXEC
    assign PC_INC     = inc_q | (jz_q & ~ZERO_FLAG) | stall_last;
    assign PC_LD      = ld_q | (jz_q & ZERO_FLAG);
    assign PC_LD_ADDR = addr_q;
    assign IR         = ir_q;
    assign ACC_LD     = acc_q;
    assign ALU_OP     = alu_q;
    assign OPERAND    = operand;
    assign OUT_LD     = out_q;
    assign HALTED     = (state_q == S_HALT);
    assign ILLEGAL    = ill_q;
    assign STATE      = state_q;
    assign RETIRED    = retired_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: instruction table plus
// hand-written stall, RUN-drop, reset, halt and wrap sequences.
module tb_cpu_sequencer;

    logic       CLK = 1'b0;
    logic       RST;
    logic       RUN;
    logic [7:0] ROM_DATA;
    logic       ZERO_FLAG;
    logic       PC_INC;
    logic       PC_LD;
    logic [3:0] PC_LD_ADDR;
    logic [7:0] IR;
    logic       ACC_LD;
    logic [2:0] ALU_OP;
    logic [3:0] OPERAND;
    logic       OUT_LD;
    logic       HALTED;
    logic       ILLEGAL;
    logic [2:0] STATE;
    logic [7:0] RETIRED;

    int pass_cnt = 0;
    int total_cnt = 0;

    cpu_sequencer dut (
        .CLK        (CLK),
        .RST        (RST),
        .RUN        (RUN),
        .ROM_DATA   (ROM_DATA),
        .ZERO_FLAG  (ZERO_FLAG),
        .PC_INC     (PC_INC),
        .PC_LD      (PC_LD),
        .PC_LD_ADDR (PC_LD_ADDR),
        .IR         (IR),
        .ACC_LD     (ACC_LD),
        .ALU_OP     (ALU_OP),
        .OPERAND    (OPERAND),
        .OUT_LD     (OUT_LD),
        .HALTED     (HALTED),
        .ILLEGAL    (ILLEGAL),
        .STATE      (STATE),
        .RETIRED    (RETIRED)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] instr;
        logic       zf;
        logic       inc;
        logic       ld;
        logic [3:0] addr;
        logic       acc;
        logic [2:0] alu;
        logic       out;
        logic       ill;
    } vec_t;

    vec_t tbl [16];

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [4:0] strobes();
        return {PC_INC, PC_LD, ACC_LD, OUT_LD, ILLEGAL};
    endfunction

    initial begin
        tbl[0]  = '{8'h00, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 3'd0, 1'b0, 1'b0};
        tbl[1]  = '{8'h15, 1'b0, 1'b1, 1'b0, 4'h0, 1'b1, 3'd0, 1'b0, 1'b0};
        tbl[2]  = '{8'h23, 1'b0, 1'b1, 1'b0, 4'h0, 1'b1, 3'd1, 1'b0, 1'b0};
        tbl[3]  = '{8'h34, 1'b0, 1'b1, 1'b0, 4'h0, 1'b1, 3'd2, 1'b0, 1'b0};
        tbl[4]  = '{8'h45, 1'b0, 1'b1, 1'b0, 4'h0, 1'b1, 3'd3, 1'b0, 1'b0};
        tbl[5]  = '{8'h56, 1'b0, 1'b1, 1'b0, 4'h0, 1'b1, 3'd4, 1'b0, 1'b0};
        tbl[6]  = '{8'h67, 1'b0, 1'b1, 1'b0, 4'h0, 1'b1, 3'd5, 1'b0, 1'b0};
        tbl[7]  = '{8'h90, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 3'd0, 1'b1, 1'b0};
        tbl[8]  = '{8'h7A, 1'b0, 1'b0, 1'b1, 4'hA, 1'b0, 3'd0, 1'b0, 1'b0};
        tbl[9]  = '{8'hF0, 1'b0, 1'b0, 1'b1, 4'h0, 1'b0, 3'd0, 1'b0, 1'b0};
        tbl[10] = '{8'h84, 1'b1, 1'b0, 1'b1, 4'h4, 1'b0, 3'd0, 1'b0, 1'b0};
        tbl[11] = '{8'h84, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 3'd0, 1'b0, 1'b0};
        tbl[12] = '{8'hA0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 3'd0, 1'b0, 1'b0};
        tbl[13] = '{8'hB0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 3'd0, 1'b0, 1'b1};
        tbl[14] = '{8'hC5, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 3'd0, 1'b0, 1'b1};
        tbl[15] = '{8'hD0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 3'd0, 1'b0, 1'b1};

        RST = 1'b0;
        RUN = 1'b1;
        ROM_DATA = 8'h15;
        ZERO_FLAG = 1'b0;
        tick();
        tick();
        check("rst_state", 32'(STATE), 32'd0);
        check("rst_strobes", 32'(strobes()), 32'd0);
        check("rst_retired", 32'(RETIRED), 32'd0);
        check("rst_halted", 32'(HALTED), 32'd0);
        check("rst_addr", 32'(PC_LD_ADDR), 32'd0);
        check("rst_ir", 32'(IR), 32'd0);

        RST = 1'b1;
        tick();
        check("first_fetch", 32'(STATE), 32'd1);

        for (int i = 0; i < 16; i++) begin
            ROM_DATA = tbl[i].instr;
            ZERO_FLAG = tbl[i].zf;
            tick();
            check("dec_state", 32'(STATE), 32'd2);
            check("dec_strobes", 32'(strobes()), 32'd0);
            tick();
            check("exec_state", 32'(STATE), 32'd3);
            check("exec_ir", 32'(IR), 32'(tbl[i].instr));
            check("exec_pc_inc", 32'(PC_INC), 32'(tbl[i].inc));
            check("exec_pc_ld", 32'(PC_LD), 32'(tbl[i].ld));
            if (tbl[i].ld)
                check("exec_addr", 32'(PC_LD_ADDR), 32'(tbl[i].addr));
            check("exec_acc_ld", 32'(ACC_LD), 32'(tbl[i].acc));
            if (tbl[i].acc)
                check("exec_alu_op", 32'(ALU_OP), 32'(tbl[i].alu));
            check("exec_out_ld", 32'(OUT_LD), 32'(tbl[i].out));
            check("exec_illegal", 32'(ILLEGAL), 32'(tbl[i].ill));
            tick();
            check("retired", 32'(RETIRED), 32'(i + 1));
            check("next_fetch", 32'(STATE), 32'd1);
            check("ill_pulse", 32'(ILLEGAL), 32'd0);
        end

        // WAIT 3: three STALL cycles, PC_INC only in the last
        ZERO_FLAG = 1'b0;
        ROM_DATA = 8'hA3;
        tick();
        tick();
        check("wait_exec_inc", 32'(PC_INC), 32'd0);
        for (int k = 1; k <= 3; k++) begin
            tick();
            check("wait_stall_state", 32'(STATE), 32'd4);
            check("wait_stall_inc", 32'(PC_INC), 32'(k == 3));
        end
        tick();
        check("wait_done_state", 32'(STATE), 32'd1);
        check("wait_retired", 32'(RETIRED), 32'd17);

        // RUN dropped in DECODE: OUT still completes, then IDLE
        ROM_DATA = 8'h90;
        tick();
        RUN = 1'b0;
        tick();
        check("rundrop_out", 32'(OUT_LD), 32'd1);
        tick();
        check("rundrop_idle", 32'(STATE), 32'd0);
        check("rundrop_retired", 32'(RETIRED), 32'd18);
        tick();
        check("idle_hold", 32'(STATE), 32'd0);
        RUN = 1'b1;
        tick();
        check("idle_to_fetch", 32'(STATE), 32'd1);

        // Async reset in the final STALL cycle drops PC_INC at once
        ROM_DATA = 8'hA2;
        tick();
        tick();
        tick();
        tick();
        check("rst_stall_pre", 32'({STATE, PC_INC}), 32'({3'd4, 1'b1}));
        RST = 1'b0;
        #1;
        check("rst_stall_state", 32'(STATE), 32'd0);
        check("rst_stall_inc", 32'(PC_INC), 32'd0);
        check("rst_stall_retired", 32'(RETIRED), 32'd0);

        // HLT is sticky regardless of RUN
        tick();
        RST = 1'b1;
        tick();
        ROM_DATA = 8'hE0;
        tick();
        tick();
        check("hlt_exec_strobes", 32'(strobes()), 32'd0);
        tick();
        check("hlt_halted", 32'(HALTED), 32'd1);
        check("hlt_state", 32'(STATE), 32'd5);
        check("hlt_retired", 32'(RETIRED), 32'd1);
        for (int k = 0; k < 20; k++) begin
            RUN = k[0];
            tick();
            check("hlt_sticky", 32'({HALTED, strobes()}), 32'({1'b1, 5'd0}));
        end
        RST = 1'b0;
        #1;
        check("hlt_cleared", 32'(HALTED), 32'd0);

        // Retired counter wraps after 256 instructions
        tick();
        RUN = 1'b1;
        RST = 1'b1;
        ROM_DATA = 8'h00;
        tick();
        for (int i = 0; i < 256; i++) begin
            tick();
            tick();
            tick();
            if (i == 254) check("retired_max", 32'(RETIRED), 32'd255);
        end
        check("retired_wrap", 32'(RETIRED), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
Fetch/decode/execute controller for the 4-bit-address microprocessor core. It sequences the program counter and the 16x8 ROM, and latches the instruction into its own instruction register. It issues one-cycle control strobes to the accumulator/ALU and output register, and handles jumps, conditional jumps, timed stalls, halt and the in-code reset instruction. It replaces free-running PC operation with a 3-state instruction cycle.

Parameters:
ADDR_W, 4, program counter / ROM address width
DATA_W, 8, instruction width; opcode = [DATA_W-1:DATA_W-4], operand = low ADDR_W bits
CNT_W, 8, width of retired-instruction counter

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  asynchronous, active-low reset
RUN  in  1  level; 1 = execute program, 0 = stop at next instruction boundary
ROM_DATA  in  DATA_W  instruction byte from ROM at current PC (combinational)
ZERO_FLAG  in  1  accumulator==0 flag from ALU
PC_INC  out  1  one-cycle strobe: PC <= PC+1
PC_LD  out  1  one-cycle strobe: PC <= PC_LD_ADDR
PC_LD_ADDR  out  ADDR_W  jump target
IR  out  DATA_W  latched instruction
ACC_LD  out  1  one-cycle strobe: accumulator <= ALU result
ALU_OP  out  3  ALU function, valid while ACC_LD=1
OPERAND  out  ADDR_W  IR operand field (immediate)
OUT_LD  out  1  one-cycle strobe: output register <= accumulator
HALTED  out  1  level, 1 in HALT state
ILLEGAL  out  1  one-cycle pulse on unused opcode
STATE  out  3  current state encoding (debug)
RETIRED  out  CNT_W  count of completed instructions, wraps

Behaviour:
- Reset (RST=0, async):
  - state=IDLE; IR=0; RETIRED=0; wait counter=0.
  - All strobes 0; HALTED=0; PC_LD_ADDR=0.
- States (STATE encoding): IDLE=0, FETCH=1, DECODE=2, EXEC=3, STALL=4, HALT=5.
- IDLE -> FETCH when RUN=1, otherwise stay.
- FETCH: IR <= ROM_DATA at the clock edge; -> DECODE.
- DECODE: registers control outputs for EXEC; -> EXEC.
- EXEC: strobes are high for exactly this cycle. 3 cycles per instruction, except WAIT.
- Opcodes (IR[7:4]):
  - 0 NOP: PC_INC.
  - 1 LDI: ACC_LD, ALU_OP=0 (pass operand), PC_INC.
  - 2 ADD: ALU_OP=1. 3 SUB: ALU_OP=2. 4 AND: ALU_OP=3. 5 OR: ALU_OP=4. 6 XOR: ALU_OP=5. Each also asserts ACC_LD and PC_INC.
  - 7 JMP: PC_LD, PC_LD_ADDR=operand, no PC_INC.
  - 8 JZ: ZERO_FLAG is sampled in EXEC. If 1: PC_LD to operand. Else: PC_INC.
  - 9 OUT: OUT_LD, PC_INC.
  - A WAIT n: EXEC loads the counter with n. If n=0: PC_INC in EXEC, as NOP. Else -> STALL for exactly n cycles; PC_INC is pulsed in the last STALL cycle.
  - E HLT: -> HALT; no PC strobe.
  - F RST: PC_LD with PC_LD_ADDR=0. IR and ACC are untouched.
  - B,C,D: ILLEGAL pulse in EXEC plus PC_INC; execution continues.
- PC_INC and PC_LD are never high in the same cycle.
- End of instruction (EXEC, or last STALL cycle):
  - RETIRED increments by 1, wrapping from 2^CNT_W-1 to 0. HLT also counts.
  - Next state: FETCH if RUN=1, IDLE if RUN=0.
  - RUN=0 mid-instruction does not abort the instruction.
- HALT: sticky. Only RST exits HALT; RUN is ignored.
- PC wrap at 15->0 is the program counter's concern; the sequencer only strobes.
- Async reset in any state (including STALL) returns to IDLE immediately; strobes drop in the same instant, not at the next edge.

Test Plan:
- Reset/idle: hold RST=0, RUN=1 -> all strobes 0, STATE=0, RETIRED=0. Release RST with RUN=1 -> FETCH on 1st edge, first EXEC on 3rd edge.
- ALU program: ROM 0x15,0x23,0x90 (LDI 5, ADD 3, OUT) -> ACC_LD with ALU_OP 0 then 1, then OUT_LD. EXEC strobes occur 3 cycles apart; RETIRED=3 after cycle 9.
- Branches: JMP 0x7A -> PC_LD=1, PC_LD_ADDR=0xA, PC_INC=0. JZ 0x84 with ZERO_FLAG=1 -> PC_LD to 4. JZ 0x84 with ZERO_FLAG=0 -> PC_INC only.
- Stall: WAIT 3 (0xA3) -> STATE=4 for exactly 3 cycles, PC_INC in the 3rd. WAIT 0 (0xA0) behaves as NOP.
- Halt/illegal/code-reset:
  - 0xB0 -> ILLEGAL 1-cycle pulse plus PC_INC.
  - 0xF0 -> PC_LD to 0.
  - 0xE0 -> HALTED=1 stays high over 20 cycles with RUN toggling; RST low clears it.
- RUN/reset boundaries:
  - Drop RUN during DECODE -> EXEC still completes, then STATE=0.
  - Assert RST during STALL -> STATE=0 and strobes 0 before the next clock edge.
